// File: rtl/break_value_scheduler.sv
// break_value_scheduler
//
// Scores the flip candidates of one selected unsatisfied clause and picks the
// cheapest to flip. For each valid candidate slot it requests a trial-flip
// evaluation and registers the returned broken-clause vector and clause mask
// into the drive registers of an external combinational break value counter.
// It then samples the counter result and keeps the strict minimum. Ties go to
// the lower slot.
//
// Optional feature (macro BVS_ZERO_EXIT_EN):
//   defined   - a break value of 0 wins immediately; remaining slots are skipped.
//   undefined - every valid slot is evaluated (same result, fixed latency).
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   start_i           start pulse, accepted only while idle
//   cand_vars_i       K candidate variable indices, slot j at [j*VAR_BITS +: VAR_BITS]
//   cand_valid_i      per-slot valid bits
//   busy_o            high whenever not idle
//   eval_req_o        flip-evaluation request, held until eval_ack_i
//   eval_var_o        variable to trial-flip (0 when no request)
//   eval_ack_i        evaluator accepted the request
//   eval_valid_i      evaluator result valid (single cycle)
//   eval_broken_i     broken-clause bits for the trial flip
//   mask_bits_i       clause-table valid mask
//   cnt_broken_o      registered broken vector driven to the counter
//   cnt_mask_o        registered mask driven to the counter
//   cnt_value_i       counter result, combinational from cnt_*_o
//   done_o            single-cycle result-valid pulse
//   best_var_o        winning variable
//   best_value_o      winning break value
//   none_valid_o      with done_o, no candidate slot was valid

module break_value_scheduler #(
    parameter int NUM_CLAUSES = 20,
    parameter int K           = 3,
    parameter int VAR_BITS    = 8,
    parameter int BV_W        = $clog2(NUM_CLAUSES) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [K*VAR_BITS-1:0] cand_vars_i,
    input  logic [K-1:0]          cand_valid_i,
    output logic                  busy_o,
    output logic                  eval_req_o,
    output logic [VAR_BITS-1:0]   eval_var_o,
    input  logic                  eval_ack_i,
    input  logic                  eval_valid_i,
    input  logic [NUM_CLAUSES-1:0] eval_broken_i,
    input  logic [NUM_CLAUSES-1:0] mask_bits_i,
    output logic [NUM_CLAUSES-1:0] cnt_broken_o,
    output logic [NUM_CLAUSES-1:0] cnt_mask_o,
    input  logic [BV_W-1:0]       cnt_value_i,
    output logic                  done_o,
    output logic [VAR_BITS-1:0]   best_var_o,
    output logic [BV_W-1:0]       best_value_o,
    output logic                  none_valid_o
);

    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, SCORE, DONE} state_t;

    state_t                              state_q, state_d;
    logic [K-1:0][VAR_BITS-1:0]          cand_q, cand_d;
    logic [K-1:0]                        valid_q, valid_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic [VAR_BITS-1:0]                 best_var_q, best_var_d;
    logic [BV_W-1:0]                     best_value_q, best_value_d;
    logic                                none_valid_q, none_valid_d;
    logic [NUM_CLAUSES-1:0]              cnt_broken_q, cnt_broken_d;
    logic [NUM_CLAUSES-1:0]              cnt_mask_q, cnt_mask_d;
    logic [IDX_W:0]                      first_slot, next_slot;
    logic                                zero_exit;

    // Lowest valid slot at or above from_slot; MSB of the result is "found".
    // Scanning downward lets the lowest matching slot overwrite the others.
    function automatic logic [IDX_W:0] find_valid(input logic [K-1:0] valid,
                                                  input int from_slot);
        logic [IDX_W:0] res;
        res = '0;
        for (int j = K - 1; j >= 0; j--) begin
            if (valid[j] && (j >= from_slot)) begin
                res = {1'b1, IDX_W'(j)};
            end
        end
        return res;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // it unassigned; a missing default here would infer a latch.
        state_d      = state_q;
        cand_d       = cand_q;
        valid_d      = valid_q;
        idx_d        = idx_q;
        best_var_d   = best_var_q;
        best_value_d = best_value_q;
        none_valid_d = none_valid_q;
        cnt_broken_d = cnt_broken_q;
        cnt_mask_d   = cnt_mask_q;
        first_slot   = find_valid(cand_valid_i, 0);
        next_slot    = find_valid(valid_q, int'(idx_q) + 1);
        zero_exit    = 1'b0;
`ifdef BVS_ZERO_EXIT_EN
        zero_exit    = (cnt_value_i == '0);
`endif

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    cand_d       = cand_vars_i;
                    valid_d      = cand_valid_i;
                    idx_d        = first_slot[IDX_W-1:0];
                    best_var_d   = '0;
                    best_value_d = '1;
                    none_valid_d = ~first_slot[IDX_W];
                    state_d      = first_slot[IDX_W] ? REQ : DONE;
                end
            end
            REQ: begin
                // A result arriving together with the ack is not a result for
                // this request; only the ack is consumed here.
                if (eval_ack_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // The counter sees only these registers, so its inputs stay
                // stable for the whole SCORE cycle.
                if (eval_valid_i) begin
                    cnt_broken_d = eval_broken_i;
                    cnt_mask_d   = mask_bits_i;
                    state_d      = SCORE;
                end
            end
            SCORE: begin
                // Strict compare: an equal value in a later slot loses.
                if (cnt_value_i < best_value_q) begin
                    best_var_d   = cand_q[idx_q];
                    best_value_d = cnt_value_i;
                end
                if (next_slot[IDX_W] && !zero_exit) begin
                    idx_d   = next_slot[IDX_W-1:0];
                    state_d = REQ;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cand_q       <= '0;
            valid_q      <= '0;
            idx_q        <= '0;
            best_var_q   <= '0;
            best_value_q <= '0;
            none_valid_q <= 1'b0;
            cnt_broken_q <= '0;
            cnt_mask_q   <= '0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            valid_q      <= valid_d;
            idx_q        <= idx_d;
            best_var_q   <= best_var_d;
            best_value_q <= best_value_d;
            none_valid_q <= none_valid_d;
            cnt_broken_q <= cnt_broken_d;
            cnt_mask_q   <= cnt_mask_d;
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign eval_req_o   = (state_q == REQ);
    assign eval_var_o   = (state_q == REQ) ? cand_q[idx_q] : '0;
    assign done_o       = (state_q == DONE);
    assign cnt_broken_o = cnt_broken_q;
    assign cnt_mask_o   = cnt_mask_q;
    assign best_var_o   = best_var_q;
    assign best_value_o = best_value_q;
    assign none_valid_o = none_valid_q;

endmodule

// File: tb/tb_break_value_scheduler.sv
// tb_break_value_scheduler
//
// Drives break_value_scheduler through directed and random sweeps. The bench
// plays both the clause evaluators (ack / result handshake) and the
// combinational break value counter (popcount of broken & mask). Expected
// winners and latencies come from a slot-list reference model.

module tb_break_value_scheduler;

    localparam int NC = 20;
    localparam int K  = 3;
    localparam int VB = 8;
    localparam int BW = $clog2(NC) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              start_i;
    logic [K*VB-1:0]   cand_vars_i;
    logic [K-1:0]      cand_valid_i;
    logic              busy_o;
    logic              eval_req_o;
    logic [VB-1:0]     eval_var_o;
    logic              eval_ack_i;
    logic              eval_valid_i;
    logic [NC-1:0]     eval_broken_i;
    logic [NC-1:0]     mask_bits_i;
    logic [NC-1:0]     cnt_broken_o;
    logic [NC-1:0]     cnt_mask_o;
    logic [BW-1:0]     cnt_value_i;
    logic              done_o;
    logic [VB-1:0]     best_var_o;
    logic [BW-1:0]     best_value_o;
    logic              none_valid_o;

    int total = 0;
    int bad   = 0;
    int cyc;

    break_value_scheduler #(.NUM_CLAUSES(NC), .K(K), .VAR_BITS(VB)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .cand_vars_i  (cand_vars_i),
        .cand_valid_i (cand_valid_i),
        .busy_o       (busy_o),
        .eval_req_o   (eval_req_o),
        .eval_var_o   (eval_var_o),
        .eval_ack_i   (eval_ack_i),
        .eval_valid_i (eval_valid_i),
        .eval_broken_i(eval_broken_i),
        .mask_bits_i  (mask_bits_i),
        .cnt_broken_o (cnt_broken_o),
        .cnt_mask_o   (cnt_mask_o),
        .cnt_value_i  (cnt_value_i),
        .done_o       (done_o),
        .best_var_o   (best_var_o),
        .best_value_o (best_value_o),
        .none_valid_o (none_valid_o)
    );

    always #5 clk = ~clk;

    // Behavioural break value counter.
    assign cnt_value_i = BW'($countones(cnt_broken_o & cnt_mask_o));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled at the negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Build a mask/broken pair whose masked popcount is exactly v, with noise
    // in the unmasked positions that the counter must ignore.
    task automatic make_vectors(input int v, output logic [NC-1:0] br, output logic [NC-1:0] mk);
        int n;
        int pos;
        mk = NC'($urandom);
        while ($countones(mk) < v) mk[$urandom_range(0, NC - 1)] = 1'b1;
        br  = '0;
        n   = 0;
        pos = $urandom_range(0, NC - 1);
        for (int i = 0; i < NC; i++) begin
            if (mk[pos] && n < v) begin
                br[pos] = 1'b1;
                n++;
            end
            pos = (pos + 1) % NC;
        end
        br = br | (NC'($urandom) & ~mk);
    endtask

    // One complete sweep. poke adds ignored start/ack/valid pulses while busy.
    task automatic run_sweep(input string tag, input logic [K*VB-1:0] vars,
                             input logic [K-1:0] vmask, input int v0, input int v1,
                             input int v2, input int ack_dly, input int val_dly,
                             input bit poke);
        int            vals[K];
        logic [VB-1:0] var_a[K];
        int            order[$];
        int            n_eval;
        int            exp_val;
        logic [VB-1:0] exp_var;
        logic [NC-1:0] br, mk;
        int            s;

        vals[0] = v0;
        vals[1] = v1;
        vals[2] = v2;
        for (int j = 0; j < K; j++) var_a[j] = vars[j*VB +: VB];

        // Reference model: valid slots in ascending order, strict minimum.
        for (int j = 0; j < K; j++) if (vmask[j]) order.push_back(j);
        n_eval  = 0;
        exp_val = NC + 1;
        exp_var = '0;
        for (int i = 0; i < order.size(); i++) begin
            n_eval++;
            if (vals[order[i]] < exp_val) begin
                exp_val = vals[order[i]];
                exp_var = var_a[order[i]];
            end
`ifdef BVS_ZERO_EXIT_EN
            if (vals[order[i]] == 0) break;
`endif
        end

        cand_vars_i  = vars;
        cand_valid_i = vmask;
        start_i      = 1'b1;
        cyc          = 0;
        tick();
        start_i      = 1'b0;
        cand_vars_i  = K*VB'($urandom);
        cand_valid_i = K'($urandom);
        check({tag, " busy"}, busy_o, 1);

        if (order.size() == 0) begin
            check({tag, " done"}, done_o, 1);
            check({tag, " none_valid"}, none_valid_o, 1);
            check({tag, " no_req"}, eval_req_o, 0);
            tick();
            check({tag, " done_drop"}, done_o, 0);
            check({tag, " idle"}, busy_o, 0);
            return;
        end

        for (int i = 0; i < n_eval; i++) begin
            s = order[i];
            check({tag, " req"}, eval_req_o, 1);
            check({tag, " var"}, eval_var_o, var_a[s]);
            for (int d = 0; d < ack_dly; d++) begin
                if (poke && d == 0) begin
                    start_i     = 1'b1;
                    cand_vars_i = K*VB'($urandom);
                end
                if (poke && d == 1) begin
                    eval_valid_i  = 1'b1;
                    eval_broken_i = '1;
                    mask_bits_i   = '1;
                end
                tick();
                start_i      = 1'b0;
                eval_valid_i = 1'b0;
                check({tag, " req_hold"}, eval_req_o, 1);
                check({tag, " var_hold"}, eval_var_o, var_a[s]);
            end
            eval_ack_i = 1'b1;
            if (poke) begin
                eval_valid_i  = 1'b1;
                eval_broken_i = '1;
                mask_bits_i   = '1;
            end
            tick();
            eval_ack_i   = 1'b0;
            eval_valid_i = 1'b0;
            check({tag, " req_drop"}, eval_req_o, 0);
            for (int d = 0; d < val_dly; d++) begin
                if (poke) eval_ack_i = 1'b1;
                tick();
                eval_ack_i = 1'b0;
            end
            make_vectors(vals[s], br, mk);
            eval_broken_i = br;
            mask_bits_i   = mk;
            eval_valid_i  = 1'b1;
            tick();
            eval_valid_i  = 1'b0;
            eval_broken_i = NC'($urandom);
            mask_bits_i   = NC'($urandom);
            check({tag, " cnt_broken"}, cnt_broken_o, br);
            check({tag, " cnt_mask"}, cnt_mask_o, mk);
            tick();
        end

        check({tag, " done"}, done_o, 1);
        check({tag, " latency"}, cyc, 1 + n_eval * (3 + ack_dly + val_dly));
        check({tag, " best_var"}, best_var_o, exp_var);
        check({tag, " best_value"}, best_value_o, exp_val);
        check({tag, " none_valid"}, none_valid_o, 0);
        tick();
        check({tag, " done_drop"}, done_o, 0);
        check({tag, " idle"}, busy_o, 0);
        check({tag, " best_var_hold"}, best_var_o, exp_var);
        check({tag, " best_value_hold"}, best_value_o, exp_val);
    endtask

    initial begin
        logic [NC-1:0] br, mk;

        reset         = 1'b0;
        start_i       = 1'b0;
        cand_vars_i   = '0;
        cand_valid_i  = '0;
        eval_ack_i    = 1'b0;
        eval_valid_i  = 1'b0;
        eval_broken_i = '0;
        mask_bits_i   = '0;
        cyc           = 0;
        tick();
        tick();
        check("rst busy", busy_o, 0);
        check("rst req", eval_req_o, 0);
        check("rst done", done_o, 0);
        check("rst best_value", best_value_o, 0);
        check("rst cnt_mask", cnt_mask_o, 0);
        reset = 1'b1;
        tick();

        run_sweep("basic", {8'd12, 8'd9, 8'd5}, 3'b111, 2, 1, 3, 0, 0, 1'b0);
        run_sweep("tie_skip", {8'd7, 8'd99, 8'd4}, 3'b101, 2, 0, 2, 0, 0, 1'b0);
        run_sweep("none", {8'd1, 8'd2, 8'd3}, 3'b000, 0, 0, 0, 0, 0, 1'b0);
        run_sweep("stall", {8'd12, 8'd9, 8'd5}, 3'b111, 2, 1, 3, 3, 4, 1'b1);
        run_sweep("zero_exit", {8'd33, 8'd22, 8'd11}, 3'b111, 3, 0, 1, 0, 0, 1'b0);

        // Reset while slot 1 is waiting for its result.
        cand_vars_i  = {8'd70, 8'd60, 8'd50};
        cand_valid_i = 3'b111;
        start_i      = 1'b1;
        tick();
        start_i      = 1'b0;
        eval_ack_i   = 1'b1;
        tick();
        eval_ack_i   = 1'b0;
        make_vectors(4, br, mk);
        eval_broken_i = br;
        mask_bits_i   = mk | 20'h1;
        eval_valid_i  = 1'b1;
        tick();
        eval_valid_i  = 1'b0;
        tick();
        check("mid var1", eval_var_o, 60);
        eval_ack_i = 1'b1;
        tick();
        eval_ack_i = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("mid_rst busy", busy_o, 0);
        check("mid_rst req", eval_req_o, 0);
        check("mid_rst var", eval_var_o, 0);
        check("mid_rst best_var", best_var_o, 0);
        check("mid_rst best_value", best_value_o, 0);
        check("mid_rst cnt_mask", cnt_mask_o, 0);
        check("mid_rst cnt_broken", cnt_broken_o, 0);
        tick();
        reset = 1'b1;
        tick();
        run_sweep("after_rst", {8'd3, 8'd2, 8'd1}, 3'b110, 9, 5, 6, 1, 0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            run_sweep("rand", K*VB'($urandom), K'($urandom),
                      $urandom_range(0, NC), $urandom_range(0, NC), $urandom_range(0, NC),
                      $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
